// File: rtl/matrix_row_bank.sv
// matrix_row_bank: SIZE x ROW_W complex row store shared by lu (client A,
// read + write-back) and triang_matrix_inv (client B, read only). Host row
// loads fill it; a valid/ready unload stream drains it row by row.
module matrix_row_bank #(
    parameter  int SIZE  = 4,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(SIZE),
    localparam int ROW_W = SIZE * 2 * WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ld_valid_i,
    output logic             ld_ready_o,
    input  logic [AW-1:0]    ld_addr_i,
    input  logic [ROW_W-1:0] ld_row_i,
    input  logic             a_rd_valid_i,
    input  logic [AW-1:0]    a_rd_addr_i,
    output logic [ROW_W-1:0] a_row_o,
    output logic [AW-1:0]    a_row_addr_o,
    output logic             a_row_valid_o,
    input  logic             a_wr_valid_i,
    input  logic [AW-1:0]    a_wr_addr_i,
    input  logic [ROW_W-1:0] a_wr_row_i,
    input  logic             b_rd_valid_i,
    input  logic [AW-1:0]    b_rd_addr_i,
    output logic [ROW_W-1:0] b_row_o,
    output logic [AW-1:0]    b_row_addr_o,
    output logic             b_row_valid_o,
    input  logic             clear_i,
    output logic [SIZE-1:0]  loaded_mask_o,
    output logic             all_loaded_o,
    input  logic             ul_start_i,
    output logic             ul_valid_o,
    input  logic             ul_ready_i,
    output logic [AW-1:0]    ul_addr_o,
    output logic [ROW_W-1:0] ul_row_o,
    output logic             ul_done_o,
    output logic             busy_o
);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [ROW_W-1:0] r_mem [SIZE];
    logic [SIZE-1:0]  r_mask;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_inc;
    logic             w_ptr_last;
    logic             w_ul_hs;
    logic             w_wr_en;
    logic [AW-1:0]    w_wr_addr;
    logic [ROW_W-1:0] w_wr_row;
    logic [SIZE-1:0]  w_wr_onehot;

    // Rows beyond SIZE exist only in the address space when SIZE is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] addr);
        return 32'(addr) < 32'(SIZE);
    endfunction

    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_ptr_last = (r_ptr == AW'(SIZE - 1));
    assign w_ul_hs    = (r_state == STREAM) && ul_ready_i;

    // Single write port: client A write-back wins, host load only when idle and unopposed.
    always_comb begin
        ld_ready_o  = ld_valid_i && !a_wr_valid_i && (r_state == IDLE) && !rst_i;
        w_wr_en     = a_wr_valid_i || ld_ready_o;
        w_wr_addr   = a_wr_valid_i ? a_wr_addr_i : ld_addr_i;
        w_wr_row    = a_wr_valid_i ? a_wr_row_i : ld_row_i;
        w_wr_onehot = '0;
        if (w_wr_en && in_range(w_wr_addr)) begin
            w_wr_onehot[w_wr_addr] = 1'b1;
        end
    end

    // Row storage write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en && in_range(w_wr_addr)) begin
            r_mem[w_wr_addr] <= w_wr_row;
        end
    end

    // Loaded-row mask; a write coinciding with clear keeps its own bit.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mask <= '0;
        end else begin
            r_mask <= (clear_i ? '0 : r_mask) | w_wr_onehot;
        end
    end

    assign loaded_mask_o = r_mask;
    assign all_loaded_o  = &r_mask;

    // Client A and B read ports, latency 1, old data on same-cycle write.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            a_row_o       <= '0;
            a_row_addr_o  <= '0;
            a_row_valid_o <= 1'b0;
            b_row_o       <= '0;
            b_row_addr_o  <= '0;
            b_row_valid_o <= 1'b0;
        end else begin
            a_row_valid_o <= a_rd_valid_i;
            b_row_valid_o <= b_rd_valid_i;
            if (a_rd_valid_i) begin
                a_row_o      <= in_range(a_rd_addr_i) ? r_mem[a_rd_addr_i] : '0;
                a_row_addr_o <= a_rd_addr_i;
            end
            if (b_rd_valid_i) begin
                b_row_o      <= in_range(b_rd_addr_i) ? r_mem[b_rd_addr_i] : '0;
                b_row_addr_o <= b_rd_addr_i;
            end
        end
    end

    // Unload FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Unload FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (ul_start_i) w_state_nxt = STREAM;
            STREAM:  if (w_ul_hs && w_ptr_last) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Unload FSM outputs decoded from state.
    always_comb begin
        ul_valid_o = (r_state == STREAM);
        busy_o     = (r_state == STREAM);
    end

    // Unload pointer and presented row; the row is snapshotted so later
    // write-backs to it do not disturb a stalled beat.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ptr     <= '0;
            ul_addr_o <= '0;
            ul_row_o  <= '0;
            ul_done_o <= 1'b0;
        end else begin
            ul_done_o <= 1'b0;
            if (r_state == IDLE && ul_start_i) begin
                r_ptr     <= '0;
                ul_addr_o <= '0;
                ul_row_o  <= r_mem[0];
            end else if (w_ul_hs) begin
                if (w_ptr_last) begin
                    r_ptr     <= '0;
                    ul_done_o <= 1'b1;
                end else begin
                    r_ptr     <= w_ptr_inc;
                    ul_addr_o <= w_ptr_inc;
                    ul_row_o  <= in_range(w_ptr_inc) ? r_mem[w_ptr_inc] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_row_bank.sv
// Directed bench for matrix_row_bank (SIZE=4, WIDTH=64).
module tb_matrix_row_bank;

    localparam int SIZE  = 4;
    localparam int WIDTH = 64;
    localparam int AW    = 2;
    localparam int ROW_W = SIZE * 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             ld_valid, ld_ready;
    logic [AW-1:0]    ld_addr;
    logic [ROW_W-1:0] ld_row;
    logic             a_rd_valid, a_row_valid, a_wr_valid;
    logic [AW-1:0]    a_rd_addr, a_row_addr, a_wr_addr;
    logic [ROW_W-1:0] a_row, a_wr_row;
    logic             b_rd_valid, b_row_valid;
    logic [AW-1:0]    b_rd_addr, b_row_addr;
    logic [ROW_W-1:0] b_row;
    logic             clear;
    logic [SIZE-1:0]  loaded_mask;
    logic             all_loaded;
    logic             ul_start, ul_valid, ul_ready, ul_done, busy;
    logic [AW-1:0]    ul_addr;
    logic [ROW_W-1:0] ul_row;

    int errors = 0;
    int checks = 0;

    logic [ROW_W-1:0] exp_mem [SIZE];
    logic [ROW_W-1:0] exp_ul;
    logic [ROW_W-1:0] ones_row;
    logic [6:0]       pat;
    int               idx;

    always #5 clk = ~clk;

    matrix_row_bank #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_addr_i(ld_addr), .ld_row_i(ld_row),
        .a_rd_valid_i(a_rd_valid), .a_rd_addr_i(a_rd_addr), .a_row_o(a_row),
        .a_row_addr_o(a_row_addr), .a_row_valid_o(a_row_valid),
        .a_wr_valid_i(a_wr_valid), .a_wr_addr_i(a_wr_addr), .a_wr_row_i(a_wr_row),
        .b_rd_valid_i(b_rd_valid), .b_rd_addr_i(b_rd_addr), .b_row_o(b_row),
        .b_row_addr_o(b_row_addr), .b_row_valid_o(b_row_valid),
        .clear_i(clear), .loaded_mask_o(loaded_mask), .all_loaded_o(all_loaded),
        .ul_start_i(ul_start), .ul_valid_o(ul_valid), .ul_ready_i(ul_ready),
        .ul_addr_o(ul_addr), .ul_row_o(ul_row), .ul_done_o(ul_done), .busy_o(busy)
    );

    task automatic check(input string tag, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Row r, element j: real = r*4+j, imag = -(r*4+j), as doubles.
    function automatic logic [ROW_W-1:0] mk_row(input int r);
        logic [ROW_W-1:0] x;
        int v;
        x = '0;
        for (int j = 0; j < SIZE; j++) begin
            v = r * 4 + j;
            x[j*128 +: 64]      = $realtobits(real'(v));
            x[j*128 + 64 +: 64] = (v == 0) ? 64'h8000_0000_0000_0000 : $realtobits(-real'(v));
        end
        return x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < 2 * SIZE; j++) ones_row[j*64 +: 64] = 64'h3FF0_0000_0000_0000;
        rst = 1'b1; ld_valid = 0; ld_addr = '0; ld_row = '0;
        a_rd_valid = 0; a_rd_addr = '0; a_wr_valid = 0; a_wr_addr = '0; a_wr_row = '0;
        b_rd_valid = 0; b_rd_addr = '0; clear = 0; ul_start = 0; ul_ready = 0;
        step(); step();
        check("rst_mask", ROW_W'(loaded_mask), '0);
        check("rst_ul_valid", ROW_W'(ul_valid), '0);
        check("rst_busy", ROW_W'(busy), '0);
        check("rst_a_valid", ROW_W'(a_row_valid), '0);
        rst = 1'b0;
        step();

        // Host loads rows 0..3.
        for (int r = 0; r < SIZE; r++) begin
            ld_valid = 1; ld_addr = AW'(r); ld_row = mk_row(r);
            exp_mem[r] = mk_row(r);
            #1;
            check("ld_ready", ROW_W'(ld_ready), 1);
            step();
            check("mask_load", ROW_W'(loaded_mask), ROW_W'((1 << (r + 1)) - 1));
            check("all_loaded", ROW_W'(all_loaded), ROW_W'(r == SIZE - 1));
        end
        ld_valid = 0;

        // Dual read of row 2, then row 0 sign-of-zero.
        a_rd_valid = 1; a_rd_addr = 2; b_rd_valid = 1; b_rd_addr = 2;
        step();
        a_rd_valid = 0; b_rd_valid = 0;
        check("a_valid", ROW_W'(a_row_valid), 1);
        check("b_valid", ROW_W'(b_row_valid), 1);
        check("a_row2", a_row, mk_row(2));
        check("b_row2", b_row, mk_row(2));
        check("a_addr2", ROW_W'(a_row_addr), 2);
        check("b_addr2", ROW_W'(b_row_addr), 2);
        a_rd_valid = 1; a_rd_addr = 0;
        step();
        a_rd_valid = 0;
        check("row0_re", ROW_W'(a_row[63:0]), '0);
        check("row0_im", ROW_W'(a_row[127:64]), ROW_W'(64'h8000_0000_0000_0000));

        // Write-back beats load; read in write cycle sees old data.
        a_wr_valid = 1; a_wr_addr = 1; a_wr_row = ones_row;
        ld_valid = 1; ld_addr = 3; ld_row = mk_row(5);
        a_rd_valid = 1; a_rd_addr = 1;
        #1;
        check("ld_refused_wr", ROW_W'(ld_ready), 0);
        step();
        a_wr_valid = 0;
        exp_mem[1] = ones_row;
        check("rd_old", a_row, mk_row(1));
        #1;
        check("ld_retry", ROW_W'(ld_ready), 1);
        step();
        ld_valid = 0;
        exp_mem[3] = mk_row(5);
        check("rd_new", a_row, ones_row);
        a_rd_addr = 3;
        step();
        a_rd_valid = 0;
        check("row3_loaded", a_row, exp_mem[3]);

        // Unload with stalls; a write-back to the presented row during a stall;
        // host load attempts must be refused throughout.
        pat = 7'b1011001;  // pat[k] is ready at beat k: 1,0,0,1,1,0,1
        ul_start = 1;
        step();
        ul_start = 0;
        ld_valid = 1; ld_addr = 0; ld_row = mk_row(11);
        idx = 0;
        exp_ul = exp_mem[0];
        for (int k = 0; k < 7; k++) begin
            ul_ready = pat[k];
            a_wr_valid = (k == 1); a_wr_addr = 1; a_wr_row = mk_row(9);
            #1;
            check("ul_valid", ROW_W'(ul_valid), 1);
            check("busy", ROW_W'(busy), 1);
            check("ld_refused_ul", ROW_W'(ld_ready), 0);
            check("ul_addr", ROW_W'(ul_addr), ROW_W'(idx));
            check("ul_row", ul_row, exp_ul);
            step();
            a_wr_valid = 0;
            if (k == 1) exp_mem[1] = mk_row(9);
            check("ul_done", ROW_W'(ul_done), ROW_W'(k == 6));
            if (pat[k]) begin
                idx++;
                if (idx < SIZE) exp_ul = exp_mem[idx];
            end
        end
        ld_valid = 0; ul_ready = 0;
        check("ul_end_valid", ROW_W'(ul_valid), 0);
        check("ul_end_busy", ROW_W'(busy), 0);
        step();
        check("ul_done_once", ROW_W'(ul_done), 0);
        a_rd_valid = 1; a_rd_addr = 0;
        step();
        a_rd_valid = 0;
        check("row0_untouched", a_row, exp_mem[0]);
        a_rd_valid = 1; a_rd_addr = 1;
        step();
        a_rd_valid = 0;
        check("row1_written", a_row, mk_row(9));

        // Clear coinciding with a row-2 write.
        clear = 1; a_wr_valid = 1; a_wr_addr = 2; a_wr_row = mk_row(2);
        step();
        clear = 0; a_wr_valid = 0;
        check("mask_clear", ROW_W'(loaded_mask), ROW_W'(4'b0100));

        // Reset in the middle of a stream.
        ul_start = 1;
        step();
        ul_start = 0; ul_ready = 1;
        step(); step();
        ul_ready = 0;
        #1;
        check("mid_addr", ROW_W'(ul_addr), 2);
        check("mid_row", ul_row, mk_row(2));
        rst = 1;
        #1;
        check("ar_valid", ROW_W'(ul_valid), 0);
        check("ar_busy", ROW_W'(busy), 0);
        check("ar_row", ul_row, '0);
        check("ar_addr", ROW_W'(ul_addr), '0);
        check("ar_mask", ROW_W'(loaded_mask), '0);
        check("ar_a_row", a_row, '0);
        step();
        rst = 0;
        check("ar_no_done", ROW_W'(ul_done), 0);
        step();
        check("ar_no_done2", ROW_W'(ul_done), 0);
        ul_start = 1;
        step();
        ul_start = 0; ul_ready = 1;
        for (int k = 0; k < SIZE; k++) begin
            #1;
            check("z_valid", ROW_W'(ul_valid), 1);
            check("z_addr", ROW_W'(ul_addr), ROW_W'(k));
            check("z_row", ul_row, '0);
            step();
        end
        ul_ready = 0;
        check("z_done", ROW_W'(ul_done), 1);
        check("z_idle", ROW_W'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
